cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl.sv | 138 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: debounced step/run/pause control of a single-cycle CPU with breakpoint and cycle limit.
//   clk       : system clock, all state on the rising edge
//   rst_n     : asynchronous active-low reset
//   btn_step  : raw single-step button (asynchronous)
//   btn_run   : raw run/pause button (asynchronous)
//   bp_en     : breakpoint enable
//   bp_addr   : breakpoint PC
//   pc        : current CPU PC
//   cpu_out   : CPU result value
//   cpu_en    : CPU clock enable, one instruction per enabled clk
//   disp_val  : snapshot of cpu_out for the display
//   cycle_cnt : saturating count of cpu_en cycles
//   state     : 0 IDLE, 1 STEP, 2 RUN, 3 HALT
//   halted    : high while in HALT
module cpu_run_ctrl #(
    parameter int          DB_CNT     = 16,
    parameter logic [31:0] MAX_CYCLES = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_step,
    input  logic        btn_run,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    input  logic [31:0] cpu_out,
    output logic        cpu_en,
    output logic [31:0] disp_val,
    output logic [31:0] cycle_cnt,
    output logic [1:0]  state,
    output logic        halted
);
    localparam int CW = $clog2(DB_CNT + 1);

    typedef enum logic [1:0] {IDLE, STEP, RUN, HALT} state_e;

    // bit 0 = step button, bit 1 = run button
    logic [1:0]         s1_q, s1_d, s2_q, s2_d, prv_q, prv_d, lvl_q, lvl_d, arm_q, arm_d, vld_q, vld_d;
    logic [1:0][CW-1:0] len_q, len_d;
    logic [1:0]         acc, rise;
    logic               step_p, run_p, hit, lim;
    state_e             state_q, state_d;
    logic               skip_q, skip_d, lock_q, lock_d, halted_q, halted_d, en_q, en_d;
    logic [31:0]        cnt_q, cnt_d, dv_q, dv_d;

    // len counts consecutive equal synchronized samples (saturating at DB_CNT);
    // vld masks the reset zeros still sitting in the synchronizer. A button is
    // armed only once a debounced low has been seen, so a button held through
    // reset release must be released and pressed again.
    always_comb begin
        vld_d = {vld_q[0], 1'b1};
        s1_d  = {btn_run, btn_step};
        s2_d  = s1_q;
        prv_d = s2_q;
        for (int i = 0; i < 2; i++) begin
            len_d[i] = !vld_q[1] ? '0 :
                       (s2_q[i] == prv_q[i] && len_q[i] != '0) ?
                       (len_q[i] == CW'(DB_CNT) ? len_q[i] : len_q[i] + 1'b1) : CW'(1);
            acc[i]   = len_d[i] == CW'(DB_CNT);
            lvl_d[i] = acc[i] ? s2_q[i] : lvl_q[i];
            arm_d[i] = arm_q[i] | (acc[i] & ~s2_q[i]);
            rise[i]  = acc[i] & s2_q[i] & ~lvl_q[i] & arm_q[i];
        end
    end

    assign step_p = rise[0];
    assign run_p  = rise[1];
    assign hit    = bp_en && pc == bp_addr && !skip_q;
    assign lim    = MAX_CYCLES != 32'd0 && cnt_q == MAX_CYCLES;

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        lock_d  = lock_q;
        cpu_en  = 1'b0;
        case (state_q)
            IDLE: state_d = run_p ? RUN : step_p ? STEP : IDLE;
            STEP: begin
                cpu_en  = 1'b1;
                state_d = IDLE;
            end
            RUN: begin
                cpu_en  = !(hit || lim);
                skip_d  = 1'b0;
                lock_d  = lim;
                state_d = (hit || lim) ? HALT : run_p ? IDLE : RUN;
            end
            HALT: if (!lock_q) begin
                state_d = run_p ? RUN : step_p ? STEP : HALT;
                skip_d  = run_p;
            end
            default: state_d = IDLE;
        endcase
        halted_d = state_d == HALT;
        cnt_d    = (cpu_en && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
        en_d     = cpu_en;
        dv_d     = en_q ? cpu_out : dv_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            prv_q    <= '0;
            lvl_q    <= '0;
            arm_q    <= '0;
            vld_q    <= '0;
            len_q    <= '0;
            state_q  <= IDLE;
            skip_q   <= 1'b0;
            lock_q   <= 1'b0;
            halted_q <= 1'b0;
            en_q     <= 1'b0;
            cnt_q    <= '0;
            dv_q     <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            prv_q    <= prv_d;
            lvl_q    <= lvl_d;
            arm_q    <= arm_d;
            vld_q    <= vld_d;
            len_q    <= len_d;
            state_q  <= state_d;
            skip_q   <= skip_d;
            lock_q   <= lock_d;
            halted_q <= halted_d;
            en_q     <= en_d;
            cnt_q    <= cnt_d;
            dv_q     <= dv_d;
        end
    end

    assign state     = state_q;
    assign halted    = halted_q;
    assign cycle_cnt = cnt_q;
    assign disp_val  = dv_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: self-checking bench for cpu_run_ctrl with an operation-level reference model.
module tb_cpu_run_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, btn_step = 1'b0, btn_run = 1'b0, bp_en = 1'b0;
    logic [31:0] bp_addr = '0, pc0 = '0, pc1 = '0, cout0, cout1;
    logic        cpu_en0, cpu_en1, h0, h1;
    logic [31:0] disp0, disp1, cnt0, cnt1;
    logic [1:0]  st0, st1;
    int          checks = 0, errors = 0, ev0 = 0;
    int          m_state = 0, m_cnt = 0;
    logic [31:0] m_pc = '0, m_disp = '0;

    typedef struct {
        bit s;
        bit r;
        bit bpe;
        int k;
        int es;
        int ed;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [31:0] p);
        return p ^ 32'hA5A5_1234;
    endfunction

    assign cout0 = f(pc0);
    assign cout1 = f(pc1);

    // CPU stand-ins: PC advances by 4 per enabled clock
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc0 <= '0;
            pc1 <= '0;
        end else begin
            if (cpu_en0) pc0 <= pc0 + 32'd4;
            if (cpu_en1) pc1 <= pc1 + 32'd4;
        end

    always @(posedge clk) if (cpu_en0) ev0++;

    cpu_run_ctrl #(.DB_CNT(4), .MAX_CYCLES(32'd0)) u0 (
        .clk(clk), .rst_n(rst_n), .btn_step(btn_step), .btn_run(btn_run), .bp_en(bp_en),
        .bp_addr(bp_addr), .pc(pc0), .cpu_out(cout0), .cpu_en(cpu_en0), .disp_val(disp0),
        .cycle_cnt(cnt0), .state(st0), .halted(h0));

    cpu_run_ctrl #(.DB_CNT(4), .MAX_CYCLES(32'd5)) u1 (
        .clk(clk), .rst_n(rst_n), .btn_step(btn_step), .btn_run(btn_run), .bp_en(bp_en),
        .bp_addr(bp_addr), .pc(pc1), .cpu_out(cout1), .cpu_en(cpu_en1), .disp_val(disp1),
        .cycle_cnt(cnt1), .state(st1), .halted(h1));

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        m_state = 0;
        m_cnt = 0;
        m_pc = '0;
        m_disp = '0;
        cyc(10);
    endtask

    task automatic press(input bit s, input bit r);
        btn_step = s;
        btn_run = r;
        cyc(10);
        btn_step = 1'b0;
        btn_run = 1'b0;
        cyc(14);
    endtask

    // one button operation from a stable IDLE/HALT state; es/ed = expected state and executed cycles
    task automatic do_op(input string name, input bit s, input bit r, input bit bpe, input int k,
                         input int es, input int ed);
        int e0;
        e0 = ev0;
        bp_en = bpe;
        bp_addr = m_pc + 32'(4 * k);
        press(s, r);
        m_cnt += ed;
        m_pc += 32'(4 * ed);
        if (ed > 0) m_disp = f(m_pc);
        m_state = es;
        chk({name, ".state"}, 32'(st0), 32'(es));
        chk({name, ".halted"}, 32'(h0), 32'(es == 3));
        chk({name, ".cnt"}, cnt0, 32'(m_cnt));
        chk({name, ".pc"}, pc0, m_pc);
        chk({name, ".disp"}, disp0, m_disp);
        chk({name, ".pulses"}, 32'(ev0 - e0), 32'(ed));
    endtask

    initial begin
        int e0, op, k;
        tbl[0] = '{1, 0, 1, 0, 0, 1};
        tbl[1] = '{0, 1, 1, 2, 3, 2};
        tbl[2] = '{1, 0, 0, 0, 0, 1};
        tbl[3] = '{1, 1, 1, 3, 3, 3};
        tbl[4] = '{0, 1, 1, 1, 3, 1};
        tbl[5] = '{1, 0, 1, 0, 0, 1};
        tbl[6] = '{0, 1, 1, 0, 3, 0};
        tbl[7] = '{0, 1, 1, 4, 3, 4};

        cyc(2);
        #1;
        chk("rst.state", 32'(st0), 0);
        chk("rst.cpu_en", 32'(cpu_en0), 0);
        chk("rst.cnt", cnt0, 0);
        chk("rst.disp", disp0, 0);
        chk("rst.halted", 32'(h0), 0);
        do_reset();

        foreach (tbl[i]) do_op($sformatf("tbl%0d", i), tbl[i].s, tbl[i].r, tbl[i].bpe, tbl[i].k, tbl[i].es, tbl[i].ed);

        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 2);
            if (op == 0) do_op($sformatf("rnd%0d", i), 1, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 1), 0, 1);
            else begin
                k = (m_state == 3) ? $urandom_range(1, 6) : $urandom_range(0, 6);
                do_op($sformatf("rnd%0d", i), op == 2, 1, 1, k, 3, k);
            end
        end

        // bouncing buttons never settle for 4 samples
        e0 = ev0;
        for (int i = 0; i < 10; i++) begin
            btn_step = ~btn_step;
            btn_run = ~btn_run;
            cyc(2);
        end
        btn_step = 1'b0;
        btn_run = 1'b0;
        cyc(12);
        chk("bounce.cnt", cnt0, 32'(m_cnt));
        chk("bounce.state", 32'(st0), 32'(m_state));
        chk("bounce.pulses", 32'(ev0 - e0), 0);

        // breakpoint at 0x0C, then resume past it
        do_reset();
        bp_en = 1'b1;
        bp_addr = 32'h0000_000C;
        press(0, 1);
        chk("bp.cnt", cnt0, 3);
        chk("bp.state", 32'(st0), 3);
        chk("bp.halted", 32'(h0), 1);
        chk("bp.pc", pc0, 32'h0000_000C);
        press(0, 1);
        chk("resume.state", 32'(st0), 2);
        chk("resume.past", 32'(pc0 > 32'h0000_000C), 1);

        // asynchronous reset mid-RUN, with run held across the release
        @(negedge clk);
        btn_run = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst.cpu_en", 32'(cpu_en0), 0);
        chk("arst.cnt", cnt0, 0);
        chk("arst.state", 32'(st0), 0);
        chk("arst.disp", disp0, 0);
        cyc(2);
        rst_n = 1'b1;
        e0 = ev0;
        cyc(20);
        chk("held.state", 32'(st0), 0);
        chk("held.cnt", cnt0, 0);
        chk("held.pulses", 32'(ev0 - e0), 0);
        btn_run = 1'b0;
        cyc(14);

        // step and run together: run wins
        bp_en = 1'b0;
        press(1, 1);
        chk("both.state", 32'(st0), 2);

        // cycle limit of 5 locks HALT until reset
        do_reset();
        bp_en = 1'b0;
        press(0, 1);
        chk("lim.cnt", cnt1, 5);
        chk("lim.state", 32'(st1), 3);
        chk("lim.halted", 32'(h1), 1);
        chk("lim.pc", pc1, 32'd20);
        press(1, 0);
        press(0, 1);
        chk("lock.cnt", cnt1, 5);
        chk("lock.state", 32'(st1), 3);
        chk("lock.pc", pc1, 32'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
